// File: rtl/tmds_encoder_nch.sv
// -----------------------------------------------------------------------------
// tmds_encoder_nch
//
// N-channel TMDS 8b/10b encoder for the pixel-clock domain. Each lane is an
// independent, identical encoder. All lanes share de_i and vgb_i, so every lane
// has the same timing and the lanes stay word-aligned.
//
// Pipeline
//   stage 1 (registered) : transition-minimised q_m[8:0], its ones/zeros
//                          counts, plus de, vgb and the per-lane ctrl bits
//   stage 2              : DC-balance / control-token / guard-band selection
//                          and the per-lane running disparity counter
//   output (optional)    : extra register when OutReg = 1
//   Latency is 2 cycles with OutReg = 1 and 1 cycle with OutReg = 0. It is the
//   same for video, control and guard-band words.
//
// Handshake: none. The block is a free-running stream and takes one word per
// lane every cycle without stalls.
//
// Parameters
//   NumChannels : number of TMDS lanes (>= 1)
//   HdmiMode    : 1 = honour vgb_i (video guard band), 0 = DVI, ignore vgb_i
//   OutReg      : 1 = add an output register stage
//
// Ports
//   clk_i   : pixel clock
//   rst_ni  : asynchronous active-low reset
//   de_i    : data enable (1 = video period)
//   data_i  : pixel bytes, lane k on data_i[8k+7:8k]
//   ctrl_i  : {C1,C0} per lane, lane k on ctrl_i[2k+1:2k]; lane 0 = {VS,HS}
//   vgb_i   : video guard-band request (HdmiMode = 1 and de_i = 0 only)
//   tmds_o  : encoded words, lane k on tmds_o[10k+9:10k], bit 0 sent first
// -----------------------------------------------------------------------------
module tmds_encoder_nch #(
    parameter int NumChannels = 3,
    parameter bit HdmiMode    = 1'b0,
    parameter bit OutReg      = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      de_i,
    input  logic [8*NumChannels-1:0]  data_i,
    input  logic [2*NumChannels-1:0]  ctrl_i,
    input  logic                      vgb_i,
    output logic [10*NumChannels-1:0] tmds_o
);

    localparam logic [9:0] TokCtrl00 = 10'b1101010100;
    localparam logic [9:0] TokCtrl01 = 10'b0010101011;
    localparam logic [9:0] TokCtrl10 = 10'b0101010100;
    localparam logic [9:0] TokCtrl11 = 10'b1010101011;
    localparam logic [9:0] GbEven    = 10'b1011001100;
    localparam logic [9:0] GbOdd     = 10'b0100110011;

    typedef struct packed {
        logic signed [4:0] cnt;
        logic [9:0]        word;
    } enc_t;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] acc;
        acc = 4'd0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + {3'b000, d[i]};
        end
        return acc;
    endfunction

    // XNOR chaining is chosen for bytes that have many ones, which keeps the
    // number of transitions in q_m[7:0] low. q_m[8] records which chain was used.
    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = 9'd0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TokCtrl00;
            2'b01:   t = TokCtrl01;
            2'b10:   t = TokCtrl10;
            default: t = TokCtrl11;
        endcase
        return t;
    endfunction

    // Stage-2 word selection and the next value of the disparity counter.
    // Non-video words always leave the counter at zero.
    function automatic enc_t encode_stage2(
        input logic [8:0]        qm,
        input logic [3:0]        n1,
        input logic [3:0]        n0,
        input logic signed [4:0] cnt,
        input logic              de,
        input logic              gb,
        input logic [1:0]        ctrl,
        input logic              odd_lane
    );
        enc_t              r;
        logic signed [4:0] n1_s;
        logic signed [4:0] n0_s;
        logic signed [4:0] two_q8;
        logic signed [4:0] two_nq8;
        n1_s    = signed'({1'b0, n1});
        n0_s    = signed'({1'b0, n0});
        two_q8  = qm[8] ? 5'sd2 : 5'sd0;
        two_nq8 = qm[8] ? 5'sd0 : 5'sd2;
        r.cnt   = 5'sd0;
        r.word  = TokCtrl00;
        if (!de) begin
            r.word = gb ? (odd_lane ? GbOdd : GbEven) : ctrl_token(ctrl);
            r.cnt  = 5'sd0;
        end else if ((cnt == 5'sd0) || (n1 == n0)) begin
            r.word = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            r.cnt  = cnt + (qm[8] ? (n1_s - n0_s) : (n0_s - n1_s));
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            r.word = {1'b1, qm[8], ~qm[7:0]};
            r.cnt  = cnt + two_q8 + (n0_s - n1_s);
        end else begin
            r.word = {1'b0, qm[8], qm[7:0]};
            r.cnt  = cnt - two_nq8 + (n1_s - n0_s);
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- stage 1
    logic       de_d, de_q;
    logic       vgb_d, vgb_q;
    logic [8:0] qm_d   [NumChannels];
    logic [8:0] qm_q   [NumChannels];
    logic [3:0] n1_d   [NumChannels];
    logic [3:0] n1_q   [NumChannels];
    logic [3:0] n0_d   [NumChannels];
    logic [3:0] n0_q   [NumChannels];
    logic [1:0] ctrl_d [NumChannels];
    logic [1:0] ctrl_q [NumChannels];

    always_comb begin
        de_d  = de_i;
        vgb_d = vgb_i;
        for (int ch = 0; ch < NumChannels; ch++) begin
            qm_d[ch]   = transition_min(data_i[8*ch +: 8]);
            n1_d[ch]   = popcount8(qm_d[ch][7:0]);
            n0_d[ch]   = 4'd8 - n1_d[ch];
            ctrl_d[ch] = ctrl_i[2*ch +: 2];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            de_q  <= 1'b0;
            vgb_q <= 1'b0;
            for (int ch = 0; ch < NumChannels; ch++) begin
                qm_q[ch]   <= 9'd0;
                n1_q[ch]   <= 4'd0;
                n0_q[ch]   <= 4'd0;
                ctrl_q[ch] <= 2'b00;
            end
        end else begin
            de_q  <= de_d;
            vgb_q <= vgb_d;
            for (int ch = 0; ch < NumChannels; ch++) begin
                qm_q[ch]   <= qm_d[ch];
                n1_q[ch]   <= n1_d[ch];
                n0_q[ch]   <= n0_d[ch];
                ctrl_q[ch] <= ctrl_d[ch];
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    // de has priority over the guard-band request. In DVI mode it is never set.
    logic                     gb_active;
    logic signed [4:0]        cnt_d [NumChannels];
    logic signed [4:0]        cnt_q [NumChannels];
    enc_t                     enc   [NumChannels];
    logic [10*NumChannels-1:0] tmds_d;

    assign gb_active = HdmiMode && vgb_q && !de_q;

    always_comb begin
        tmds_d = '0;
        for (int ch = 0; ch < NumChannels; ch++) begin
            enc[ch] = encode_stage2(qm_q[ch], n1_q[ch], n0_q[ch], cnt_q[ch],
                                    de_q, gb_active, ctrl_q[ch], ch[0]);
            cnt_d[ch]            = enc[ch].cnt;
            tmds_d[10*ch +: 10]  = enc[ch].word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int ch = 0; ch < NumChannels; ch++) begin
                cnt_q[ch] <= 5'sd0;
            end
        end else begin
            for (int ch = 0; ch < NumChannels; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    // ---------------------------------------------------------------- output
    // Without the output register, tmds_o follows the reset-cleared stage-1
    // state, so it still shows the 00 control token during reset.
    if (OutReg) begin : g_out_reg
        logic [10*NumChannels-1:0] tmds_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                tmds_q <= {NumChannels{TokCtrl00}};
            end else begin
                tmds_q <= tmds_d;
            end
        end
        assign tmds_o = tmds_q;
    end else begin : g_out_comb
        assign tmds_o = tmds_d;
    end

endmodule

// File: doc/tmds_encoder_nch.md
# tmds_encoder_nch

Parametrised N-channel TMDS 8b/10b encoder with running-disparity tracking, control-token generation and optional HDMI video guard-band insertion. It sits in the pixel-clock domain between the frame-buffer reader's RGB/DE/sync outputs and the per-channel 10:1 output serializers. It replaces the fixed three-channel DVI-only encoder. Timing is identical on every channel, so all lanes stay word-aligned.

## Interface
- NumChannels, 3: number of TMDS data lanes (≥1).
- HdmiMode, 1'b0: 1 enables video guard-band insertion on vgb_i; 0 gives DVI behaviour and ignores vgb_i.
- OutReg, 1'b1: 1 adds an output register stage, for latency 2. 0 gives latency 1.

Ports:
- clk_i  in  1  pixel clock; the only clock in the block.
- rst_ni  in  1  reset, asynchronous, active-low.
- de_i  in  1  data enable. 1 = video period.
- data_i  in  8*NumChannels  pixel bytes. Channel k uses data_i[8k+7:8k].
- ctrl_i  in  2*NumChannels  control bits {C1,C0} per channel, used when de_i=0. Channel 0 carries {VSync,HSync}.
- vgb_i  in  1  video guard-band request. Honoured only when HdmiMode=1 and de_i=0.
- tmds_o  out  10*NumChannels  encoded words. Channel k uses tmds_o[10k+9:10k]. Bit 0 is transmitted first.

## Operation
- All channels are independent identical encoders fed from the shared de_i and vgb_i.
- Stage 1, registered:
  - Compute N1(D), the number of ones in the data byte.
  - If N1>4, or N1==4 with D[0]==0, use XNOR: q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0.
  - Otherwise use XOR with q_m[8]=1.
  - Register q_m[8:0], N1(q_m[7:0]), N0=8-N1, de, vgb and ctrl.
- Stage 2, per channel, using a disparity counter cnt (5-bit signed):
  - Guard band (de=0, vgb=1, HdmiMode=1): even channels emit 1011001100, odd channels emit 0100110011. Set cnt to 0.
  - Control (de=0, otherwise): ctrl 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011. Set cnt to 0.
  - Video, case cnt==0 or N1==N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - Video, case (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt = cnt + 2·q_m[8] + (N0-N1).
  - Video, all other cases:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt = cnt − 2·(~q_m[8]) + (N1-N0).
- All arithmetic is signed 5-bit. |cnt| never exceeds 10 by construction, so there is no saturation logic.
- Simultaneous de_i=1 and vgb_i=1: de_i wins, the word is encoded as video and vgb_i is ignored.
- HdmiMode=0: vgb_i has no effect; control tokens are emitted instead.

## Timing
- Latency, input to tmds_o: 2 cycles with OutReg=1, 1 cycle with OutReg=0. The latency is the same for video, control and guard-band words.
- Throughput: one word per channel every cycle. There are no stalls and no handshake.
- Reset (rst_ni=0, asynchronous):
  - All pipeline registers clear to de=0, vgb=0, ctrl=00.
  - tmds_o = 1101010100 on every channel immediately.
  - Every cnt is 0.
- Reset release: the first input-dependent word appears at the stated latency. Earlier outputs stay at the 00 control token.
- Reset mid-line: tmds_o drops to the control token asynchronously and cnt clears. Encoding restarts from cnt=0 at the first video word after release.
- The DE 1→0 transition clears cnt in the same cycle that the control word is emitted.

## Test plan
- Reset: assert rst_ni=0 mid-stream → tmds_o on all channels is 1101010100 asynchronously. After release with de_i=0 and ctrl_i=0, the output is unchanged.
- Control tokens: de_i=0 and ctrl_i on channel 0 stepping 00,01,10,11 → 1101010100, 0010101011, 0101010100, 1010101011, each 2 cycles later (OutReg=1).
- Disparity sequence: de_i=1 with data 0x00 on three consecutive cycles from cnt=0 → words 0x100, 0x3FF, 0x100; cnt goes −8, +2, −6.
- DC balance: 10000 random bytes with de_i=1, then compare against a reference model → bit-exact outputs on all NumChannels=4 lanes, and |cnt|≤10 throughout.
- Guard band: HdmiMode=1, vgb_i=1, de_i=0 for 2 cycles → channels 0 and 2 emit 1011001100 and channels 1 and 3 emit 0100110011. With de_i=1 in the same cycle, a video word is emitted instead. With HdmiMode=0, control tokens are emitted instead.
- Latency mode: OutReg=0 → every scenario above shifts one cycle earlier with identical values.
